// File: rtl/fft_n_radix2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fft_n_radix2
// Brief    : Dual-stream N-point radix-2 DIT FFT, shared fully-unrolled pipeline.
// Revision : 1.0 - initial release
// ============================================================================

package fft_n_radix2_pkg;
  typedef struct packed {
    logic signed [31:0] r;
    logic signed [31:0] i;
  } complex_product_t;
endpackage

module fft_n_radix2
  import fft_n_radix2_pkg::*;
#(
  parameter int N       = 8,
  parameter int TW_FRAC = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  complex_product_t         data_in_0,
  input  complex_product_t         data_in_1,
  output complex_product_t [N-1:0] fft_out,
  output logic                     output_mode,
  output logic                     out_valid
);

  localparam int     NUM_STAGES      = $clog2(N);
  localparam int     NUM_BUTTERFLIES = N / 2;
  localparam int     CNT_W           = (NUM_STAGES < 1) ? 1 : NUM_STAGES;
  localparam int     C_QF            = 28;
  localparam longint C_PI_Q          = 64'd843314857;

  function automatic int f_bitrev(input int v);
    int r;
    r = 0;
    for (int b = 0; b < NUM_STAGES; b++)
      if (v[b]) r = r | (1 << (NUM_STAGES - 1 - b));
    return r;
  endfunction

  // Elaboration-time Taylor series in Q28 fixed point; angles stay below pi.
  function automatic longint f_taylor(input longint x, input bit is_sin);
    longint term, sum;
    term = is_sin ? x : (longint'(1) <<< C_QF);
    sum  = term;
    for (int n = 1; n < 16; n++) begin
      term = (term * x) >>> C_QF;
      term = (term * x) >>> C_QF;
      if (is_sin) term = -term / longint'((2 * n) * (2 * n + 1));
      else        term = -term / longint'((2 * n - 1) * (2 * n));
      sum = sum + term;
    end
    return sum;
  endfunction

  function automatic int f_twiddle(input int k, input bit is_sin);
    longint x, v, half;
    x    = (2 * C_PI_Q * longint'(k)) / longint'(N);
    v    = f_taylor(x, is_sin);
    if (is_sin) v = -v;
    half = longint'(1) <<< (C_QF - TW_FRAC - 1);
    if (v >= 0) return int'((v + half) >>> (C_QF - TW_FRAC));
    return -int'((-v + half) >>> (C_QF - TW_FRAC));
  endfunction

  logic [CNT_W-1:0]         r_cnt;
  complex_product_t [N-1:0] r_buf0, r_buf1;
  complex_product_t [N-1:0] w_buf0_nxt, w_buf1_nxt;
  complex_product_t [N-1:0] w_rev0, w_rev1;
  logic                     w_frame_done;

  assign w_frame_done = enable && (r_cnt == CNT_W'(N - 1));

  always_comb begin
    w_buf0_nxt = r_buf0;
    w_buf1_nxt = r_buf1;
    if (enable) begin
      w_buf0_nxt[r_cnt] = data_in_0;
      w_buf1_nxt[r_cnt] = data_in_1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else begin
      r_buf0 <= w_buf0_nxt;
      r_buf1 <= w_buf1_nxt;
      if (enable) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Stream 0 issues from the next-state view so the sample accepted at the
  // completing edge is included; stream 1 issues a cycle later from storage.
  for (genvar p = 0; p < N; p++) begin : g_bitrev
    assign w_rev0[p] = w_buf0_nxt[f_bitrev(p)];
    assign w_rev1[p] = r_buf1[f_bitrev(p)];
  end

  complex_product_t [N-1:0] r_issue_data;
  logic                     r_issue_valid, r_issue_mode, r_issue1_pend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_issue_data  <= '0;
      r_issue_valid <= 1'b0;
      r_issue_mode  <= 1'b0;
      r_issue1_pend <= 1'b0;
    end else if (w_frame_done) begin
      r_issue_data  <= w_rev0;
      r_issue_valid <= 1'b1;
      r_issue_mode  <= 1'b0;
      r_issue1_pend <= 1'b1;
    end else if (r_issue1_pend) begin
      r_issue_data  <= w_rev1;
      r_issue_valid <= 1'b1;
      r_issue_mode  <= 1'b1;
      r_issue1_pend <= 1'b0;
    end else begin
      r_issue_valid <= 1'b0;
    end
  end

  complex_product_t [N-1:0] w_sd [NUM_STAGES+1];
  logic                     w_sv [NUM_STAGES+1];
  logic                     w_sm [NUM_STAGES+1];

  assign w_sd[0] = r_issue_data;
  assign w_sv[0] = r_issue_valid;
  assign w_sm[0] = r_issue_mode;

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int C_SPAN = 1 << s;
    complex_product_t [N-1:0] w_nxt;
    complex_product_t [N-1:0] r_data;
    logic                     r_valid, r_mode;

    for (genvar bf = 0; bf < NUM_BUTTERFLIES; bf++) begin : g_bfly
      localparam int C_J  = bf % C_SPAN;
      localparam int C_IA = (bf / C_SPAN) * 2 * C_SPAN + C_J;
      localparam int C_IB = C_IA + C_SPAN;
      localparam int C_K  = C_J * (N >> (s + 1));
      complex_product_t w_a, w_b, w_t;

      assign w_a = w_sd[s][C_IA];
      assign w_b = w_sd[s][C_IB];

      if (C_K == 0) begin : g_bypass
        assign w_t = w_b;
      end else begin : g_cmul
        localparam logic signed [63:0] C_WR = 64'(f_twiddle(C_K, 1'b0));
        localparam logic signed [63:0] C_WI = 64'(f_twiddle(C_K, 1'b1));
        logic signed [63:0] w_re_sum, w_im_sum;
        assign w_re_sum = 64'($signed(w_b.r)) * C_WR - 64'($signed(w_b.i)) * C_WI;
        assign w_im_sum = 64'($signed(w_b.r)) * C_WI + 64'($signed(w_b.i)) * C_WR;
        assign w_t.r    = 32'(w_re_sum >>> TW_FRAC);
        assign w_t.i    = 32'(w_im_sum >>> TW_FRAC);
      end

      assign w_nxt[C_IA] = {w_a.r + w_t.r, w_a.i + w_t.i};
      assign w_nxt[C_IB] = {w_a.r - w_t.r, w_a.i - w_t.i};
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_data  <= '0;
        r_valid <= 1'b0;
        r_mode  <= 1'b0;
      end else begin
        r_valid <= w_sv[s];
        if (w_sv[s]) begin
          r_data <= w_nxt;
          r_mode <= w_sm[s];
        end
      end
    end

    assign w_sd[s+1] = r_data;
    assign w_sv[s+1] = r_valid;
    assign w_sm[s+1] = r_mode;
  end

  assign fft_out     = w_sd[NUM_STAGES];
  assign out_valid   = w_sv[NUM_STAGES];
  assign output_mode = w_sm[NUM_STAGES];

endmodule

`default_nettype wire

// File: tb/tb_fft_n_radix2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fft_n_radix2
// Brief    : Directed self-checking bench for fft_n_radix2 (N = 8).
// Revision : 1.0 - initial release
// ============================================================================

module tb_fft_n_radix2;
  import fft_n_radix2_pkg::*;

  localparam int N = 8;
  typedef complex_product_t [N-1:0] vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  complex_product_t din0, din1;
  vec_t             fft_out;
  logic             output_mode;
  logic             out_valid;

  int checks = 0;
  int errors = 0;

  vec_t a0, a1, ea0, ea1, b0, b1, eb0, eb1, zero_v;

  always #5 clk = ~clk;

  fft_n_radix2 #(.N(N), .TW_FRAC(14)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .data_in_0  (din0),
    .data_in_1  (din1),
    .fft_out    (fft_out),
    .output_mode(output_mode),
    .out_valid  (out_valid)
  );

  function automatic complex_product_t cx(input int r, input int i);
    complex_product_t c;
    c.r = r;
    c.i = i;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed (%0d,%0d) expected (%0d,%0d)", tag,
             $signed(obs[63:32]), $signed(obs[31:0]), $signed(exp[63:32]), $signed(exp[31:0]));
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t obs, input vec_t exp);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s bin%0d", tag, k), obs[k], exp[k]);
  endtask

  // Returns one ns after the edge that accepts sample N-1.
  task automatic capture(input vec_t s0, input vec_t s1, input bit gaps);
    for (int n = 0; n < N; n++) begin
      enable = 1'b1;
      din0   = s0[n];
      din1   = s1[n];
      tick();
      if (gaps && (n == 2 || n == 5)) begin
        enable = 1'b0;
        din0   = cx(-12345, 999);
        din1   = cx(4321, -77);
        repeat (3) tick();
      end
    end
    enable = 1'b0;
    din0   = cx(31337, -31337);
    din1   = cx(-5, 5);
  endtask

  task automatic expect_result(input string tag, input vec_t e0, input vec_t e1);
    chk({tag, " valid@E"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, " valid@E+1"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, " valid@E+2"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, " valid@E+3"}, 64'(out_valid), 64'd1);
    chk({tag, " mode@E+3"}, 64'(output_mode), 64'd0);
    chk_vec({tag, " s0"}, fft_out, e0);
    tick();
    chk({tag, " valid@E+4"}, 64'(out_valid), 64'd1);
    chk({tag, " mode@E+4"}, 64'(output_mode), 64'd1);
    chk_vec({tag, " s1"}, fft_out, e1);
    tick();
    chk({tag, " valid@E+5"}, 64'(out_valid), 64'd0);
    chk({tag, " mode hold"}, 64'(output_mode), 64'd1);
    chk_vec({tag, " hold"}, fft_out, e1);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      a0[k]     = cx((k == 0) ? 100 : 0, 0);
      a1[k]     = cx(10, 0);
      ea0[k]    = cx(100, 0);
      ea1[k]    = cx((k == 0) ? 80 : 0, 0);
      b0[k]     = cx((k % 2 == 0) ? 1000 : -1000, 0);
      b1[k]     = (k == 1) ? cx(1000, 500) : cx(0, 0);
      eb0[k]    = cx((k == 4) ? 8000 : 0, 0);
      zero_v[k] = cx(0, 0);
    end
    // Delayed complex impulse: bin k = (1000+j500)*W8^k with floor rounding.
    eb1[0] = cx(1000, 500);    eb1[4] = cx(-1000, -500);
    eb1[1] = cx(1060, -354);   eb1[5] = cx(-1060, 354);
    eb1[2] = cx(500, -1000);   eb1[6] = cx(-500, 1000);
    eb1[3] = cx(-354, -1061);  eb1[7] = cx(354, 1061);

    reset  = 1'b0;
    enable = 1'b0;
    din0   = cx(0, 0);
    din1   = cx(0, 0);
    repeat (2) tick();
    chk("reset valid", 64'(out_valid), 64'd0);
    chk("reset mode", 64'(output_mode), 64'd0);
    chk_vec("reset out", fft_out, zero_v);
    reset = 1'b1;
    repeat (2) tick();

    capture(a0, a1, 1'b0);
    expect_result("impulse_dc", ea0, ea1);
    repeat (3) tick();

    capture(b0, b1, 1'b0);
    expect_result("nyq_twiddle", eb0, eb1);
    repeat (2) tick();

    capture(a0, a1, 1'b1);
    expect_result("gaps", ea0, ea1);
    repeat (2) tick();

    // Abort a partial frame; its samples must not complete a later frame early.
    for (int n = 0; n < 3; n++) begin
      enable = 1'b1;
      din0   = cx(777, -3);
      din1   = cx(-9, 42);
      tick();
    end
    enable = 1'b0;
    reset  = 1'b0;
    #3;
    chk("midframe async valid", 64'(out_valid), 64'd0);
    chk_vec("midframe async out", fft_out, zero_v);
    tick();
    reset = 1'b1;
    tick();
    chk("midframe post valid", 64'(out_valid), 64'd0);
    capture(a0, a1, 1'b0);
    expect_result("after_abort", ea0, ea1);
    repeat (2) tick();

    capture(a0, a1, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("midpipe async valid", 64'(out_valid), 64'd0);
    chk_vec("midpipe async out", fft_out, zero_v);
    tick();
    chk("midpipe valid@E+2", 64'(out_valid), 64'd0);
    tick();
    chk("midpipe valid@E+3", 64'(out_valid), 64'd0);
    chk_vec("midpipe out@E+3", fft_out, zero_v);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("midpipe drain%0d", c), 64'(out_valid), 64'd0);
    end
    chk_vec("midpipe final out", fft_out, zero_v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
